eth_fcs_append: RTL and testbench

//  MII-side TX finisher downstream of the JPEG/Ethernet nibble bridge.
//  - Accepts the merged nibble stream (preamble + SFD + header + payload).
//  - Pads short frames and appends the 32-bit Ethernet FCS.
//  - Enforces the inter-frame gap.
//  - Drives txd/tx_en to the PHY.

---
 rtl/eth_fcs_append_if.sv | 25 ++
 rtl/eth_fcs_append.sv | 166 ++++++++++++++++
 tb/tb_eth_fcs_append.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_fcs_append_if.sv
// MII TX side bus: merged nibble stream in, PHY nibbles and status out.
interface eth_fcs_append_if;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned CNT_W = 16;

  logic [NIB_W-1:0] with_usr;
  logic             with_usr_valid;
  logic [NIB_W-1:0] txd;
  logic             tx_en;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] frame_cnt;

  // Upstream source / observer of the finisher
  modport master (
    output with_usr, with_usr_valid,
    input  txd, tx_en, busy, err, frame_cnt
  );

  // The finisher itself
  modport slave (
    input  with_usr, with_usr_valid,
    output txd, tx_en, busy, err, frame_cnt
  );
endinterface

// File: rtl/eth_fcs_append.sv
// MII TX finisher: passes preamble/SFD/data through, pads short frames,
// appends the Ethernet FCS and enforces the inter-frame gap.
module eth_fcs_append #(
  parameter int unsigned MIN_FRAME_NIB = 120,
  parameter int unsigned IFG_NIBBLES   = 24
) (
  input  logic            eth_clk,
  input  logic            rst,
  eth_fcs_append_if.slave bus
);
  localparam int unsigned CRC_W    = 32;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned CNT_W    = 11;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned FCNT_W   = 16;
  localparam int unsigned IFG_W    = (IFG_NIBBLES > 2) ? $clog2(IFG_NIBBLES) : 1;
  localparam logic [CRC_W-1:0] CRC_POLY = 32'hEDB88320;
  localparam logic [CRC_W-1:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [NIB_W-1:0] SFD_NIB  = 4'hD;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME_NIB);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'((IFG_NIBBLES > 0) ? IFG_NIBBLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG, DROP} state_t;

  state_t             state;
  logic [CRC_W-1:0]   crc;
  logic [CNT_W-1:0]   nib_cnt;
  logic [IDX_W-1:0]   fcs_idx;
  logic [IFG_W-1:0]   ifg_cnt;
  logic [CRC_W-1:0]   fcs_word;
  logic [NIB_W-1:0]   fcs_nib;
  logic [CRC_W-1:0]   crc_data;
  logic [CRC_W-1:0]   crc_pad;
  logic [CNT_W-1:0]   cnt_inc;

  // Reflected CRC-32 advanced by one nibble, LSB first
  function automatic logic [CRC_W-1:0] crc_nib(input logic [CRC_W-1:0] c,
                                               input logic [NIB_W-1:0] d);
    logic [CRC_W-1:0] r;
    r = c;
    for (int k = 0; k < NIB_W; k++) begin
      r = (r >> 1) ^ ((r[0] ^ d[k]) ? CRC_POLY : '0);
    end
    return r;
  endfunction

  // FCS nibble select, next CRC candidates and saturating nibble count
  assign fcs_word = ~crc;
  assign fcs_nib  = fcs_word[{fcs_idx, 2'b00} +: NIB_W];
  assign crc_data = crc_nib(crc, bus.with_usr);
  assign crc_pad  = crc_nib(crc, '0);
  assign cnt_inc  = (nib_cnt == CNT_MAX) ? nib_cnt : nib_cnt + CNT_W'(1);

  // Frame sequencer with registered MII outputs and status
  always_ff @(posedge eth_clk) begin
    if (rst) begin
      state         <= IDLE;
      crc           <= CRC_INIT;
      nib_cnt       <= '0;
      fcs_idx       <= '0;
      ifg_cnt       <= '0;
      bus.txd       <= '0;
      bus.tx_en     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.err       <= 1'b0;
      bus.frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          crc       <= CRC_INIT;
          nib_cnt   <= '0;
          fcs_idx   <= '0;
          bus.tx_en <= bus.with_usr_valid;
          bus.txd   <= bus.with_usr_valid ? bus.with_usr : '0;
          if (bus.with_usr_valid) begin
            state    <= PRE;
            bus.busy <= 1'b1;
          end
        end
        PRE: begin
          if (bus.with_usr_valid) begin
            bus.txd   <= bus.with_usr;
            bus.tx_en <= 1'b1;
            if (bus.with_usr == SFD_NIB) state <= DATA;
          end else begin
            // Frame ended before any SFD: abandon it, no FCS
            bus.txd   <= '0;
            bus.tx_en <= 1'b0;
            bus.err   <= 1'b1;
            ifg_cnt   <= '0;
            state     <= IFG;
          end
        end
        DATA: begin
          bus.tx_en <= 1'b1;
          if (bus.with_usr_valid) begin
            bus.txd <= bus.with_usr;
            crc     <= crc_data;
            nib_cnt <= cnt_inc;
          end else if (nib_cnt < MIN_CNT) begin
            bus.txd <= '0;
            crc     <= crc_pad;
            nib_cnt <= cnt_inc;
            state   <= PAD;
          end else begin
            // First FCS nibble goes out immediately so tx_en never gaps
            bus.txd <= fcs_nib;
            fcs_idx <= fcs_idx + IDX_W'(1);
            state   <= FCS;
          end
        end
        PAD: begin
          bus.tx_en <= 1'b1;
          if (bus.with_usr_valid) bus.err <= 1'b1;
          if (nib_cnt >= MIN_CNT) begin
            bus.txd <= fcs_nib;
            fcs_idx <= fcs_idx + IDX_W'(1);
            state   <= FCS;
          end else begin
            bus.txd <= '0;
            crc     <= crc_pad;
            nib_cnt <= cnt_inc;
          end
        end
        FCS: begin
          bus.tx_en <= 1'b1;
          bus.txd   <= fcs_nib;
          fcs_idx   <= fcs_idx + IDX_W'(1);
          if (bus.with_usr_valid) bus.err <= 1'b1;
          if (fcs_idx == IDX_LAST) begin
            bus.frame_cnt <= bus.frame_cnt + FCNT_W'(1);
            ifg_cnt       <= '0;
            state         <= IFG;
          end
        end
        IFG: begin
          bus.tx_en <= 1'b0;
          bus.txd   <= '0;
          if (bus.with_usr_valid) bus.err <= 1'b1;
          if (ifg_cnt == IFG_LAST) begin
            state    <= bus.with_usr_valid ? DROP : IDLE;
            bus.busy <= bus.with_usr_valid;
          end else begin
            ifg_cnt <= ifg_cnt + IFG_W'(1);
          end
        end
        DROP: begin
          bus.tx_en <= 1'b0;
          bus.txd   <= '0;
          if (!bus.with_usr_valid) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          bus.busy  <= 1'b0;
          bus.tx_en <= 1'b0;
          bus.txd   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_eth_fcs_append.sv
// Bench for eth_fcs_append: two instances (padding on / off) driven from
// frame stimulus, checked by a nibble scoreboard plus status checks.
module tb_eth_fcs_append;
  localparam int unsigned MIN_NIB = 120;
  localparam int unsigned IFG_NIB = 24;

  logic eth_clk = 1'b0;
  logic rst;
  always #5 eth_clk = ~eth_clk;

  eth_fcs_append_if bus0 ();
  eth_fcs_append_if bus1 ();

  eth_fcs_append #(.MIN_FRAME_NIB(MIN_NIB), .IFG_NIBBLES(IFG_NIB)) dut0 (
    .eth_clk(eth_clk), .rst(rst), .bus(bus0));
  eth_fcs_append #(.MIN_FRAME_NIB(0), .IFG_NIBBLES(IFG_NIB)) dut1 (
    .eth_clk(eth_clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  logic [3:0] frm[$];
  logic [3:0] exp_nib[$];
  int         exp_len[$];
  int         exp_frames[2];
  bit         exp_err[2];

  logic [3:0]  m_txd[2];
  logic        m_en[2];
  logic        m_busy[2];
  logic        m_err[2];
  logic [15:0] m_cnt[2];
  assign m_txd[0] = bus0.txd;       assign m_txd[1] = bus1.txd;
  assign m_en[0]  = bus0.tx_en;     assign m_en[1]  = bus1.tx_en;
  assign m_busy[0] = bus0.busy;     assign m_busy[1] = bus1.busy;
  assign m_err[0] = bus0.err;       assign m_err[1] = bus1.err;
  assign m_cnt[0] = bus0.frame_cnt; assign m_cnt[1] = bus1.frame_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic set_in(input int s, input logic v, input logic [3:0] n);
    if (s == 0) begin bus0.with_usr_valid = v; bus0.with_usr = n; end
    else begin bus1.with_usr_valid = v; bus1.with_usr = n; end
  endtask

  task automatic drive(input int s, input logic v, input logic [3:0] n);
    set_in(s, v, n);
    @(posedge eth_clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge eth_clk); #1; end
  endtask

  // Drive frm with valid high, then drop valid in the current cycle
  task automatic send(input int s);
    foreach (frm[i]) drive(s, 1'b1, frm[i]);
    set_in(s, 1'b0, 4'h0);
  endtask

  task automatic wait_idle(input int s, input string name);
    int n = 0;
    while (m_busy[s] !== 1'b0 && n < 3000) begin cycles(1); n++; end
    if (m_busy[s] !== 1'b0) begin
      total++; bad++;
      $display("FAIL %s: timeout busy=%0b required 0", name, m_busy[s]);
    end
  endtask

  // Standard byte-wise reflected CRC-32; returns the transmitted FCS value
  function automatic logic [31:0] crc32(input logic [7:0] by[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (by[i]) begin
      c ^= {24'h0, by[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Reference: expected PHY burst for frm on an instance with given min size
  function automatic void model(input int s, input int unsigned min_nib);
    int sfd = -1;
    int base;
    logic [3:0] d[$];
    logic [7:0] by[$];
    logic [31:0] f;
    base = exp_nib.size();
    for (int i = 1; i < frm.size(); i++) if (frm[i] == 4'hD) begin sfd = i; break; end
    foreach (frm[i]) exp_nib.push_back(frm[i]);
    if (sfd < 0) begin
      exp_err[s] = 1'b1;
      exp_len.push_back(exp_nib.size() - base);
      return;
    end
    for (int i = sfd + 1; i < frm.size(); i++) d.push_back(frm[i]);
    while (d.size() < int'(min_nib)) begin d.push_back(4'h0); exp_nib.push_back(4'h0); end
    for (int i = 0; i + 1 < d.size(); i += 2) by.push_back({d[i+1], d[i]});
    f = crc32(by);
    for (int k = 0; k < 8; k++) exp_nib.push_back(f[4*k +: 4]);
    exp_len.push_back(exp_nib.size() - base);
    exp_frames[s]++;
  endfunction

  function automatic void build(input int pre, input int nbytes);
    logic [7:0] b;
    frm.delete();
    for (int i = 0; i < pre; i++) frm.push_back(4'h5);
    frm.push_back(4'hD);
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      frm.push_back(b[3:0]);
      frm.push_back(b[7:4]);
    end
  endfunction

  // Scoreboard monitor: pops one expected nibble per tx_en cycle, checks burst length
  bit in_burst[2];
  int blen[2];
  int gap[2];
  int last_gap[2];
  int last_blen[2];
  always @(negedge eth_clk) begin
    for (int s = 0; s < 2; s++) begin
      if (m_en[s] === 1'b1) begin
        if (!in_burst[s]) begin
          in_burst[s] = 1'b1; blen[s] = 0; last_gap[s] = gap[s]; gap[s] = 0;
        end
        total++;
        if (exp_nib.size() == 0) begin
          bad++;
          $display("FAIL unexpected_tx dut%0d: got tx_en=1 txd=%h required tx_en=0", s, m_txd[s]);
        end else begin
          logic [3:0] e;
          e = exp_nib.pop_front();
          if (m_txd[s] !== e) begin
            bad++;
            $display("FAIL txd dut%0d nib%0d: got %h required %h", s, blen[s], m_txd[s], e);
          end
        end
        blen[s]++;
      end else begin
        if (in_burst[s]) begin
          int el;
          in_burst[s] = 1'b0;
          last_blen[s] = blen[s];
          el = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
          total++;
          if (blen[s] != el) begin
            bad++;
            $display("FAIL burst_len dut%0d: got %0d required %0d", s, blen[s], el);
          end
        end
        gap[s]++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string msg;
    int n;
    logic [7:0] ch;
    msg = "123456789";
    rst = 1'b1;
    set_in(0, 1'b0, 4'h0);
    set_in(1, 1'b0, 4'h0);
    cycles(3);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset_tx_en%0d", s), 32'(m_en[s]), 0);
      check($sformatf("reset_txd%0d", s), 32'(m_txd[s]), 0);
      check($sformatf("reset_busy%0d", s), 32'(m_busy[s]), 0);
      check($sformatf("reset_err%0d", s), 32'(m_err[s]), 0);
      check($sformatf("reset_cnt%0d", s), 32'(m_cnt[s]), 0);
    end

    // CRC check vector on the unpadded instance, expected FCS given literally
    frm.delete();
    for (int i = 0; i < 15; i++) frm.push_back(4'h5);
    frm.push_back(4'hD);
    for (int i = 0; i < msg.len(); i++) begin
      ch = msg[i];
      frm.push_back(ch[3:0]);
      frm.push_back(ch[7:4]);
    end
    foreach (frm[i]) exp_nib.push_back(frm[i]);
    exp_nib.push_back(4'h6); exp_nib.push_back(4'h2); exp_nib.push_back(4'h9); exp_nib.push_back(4'h3);
    exp_nib.push_back(4'h4); exp_nib.push_back(4'hF); exp_nib.push_back(4'hB); exp_nib.push_back(4'hC);
    exp_len.push_back(42);
    exp_frames[1]++;
    send(1);
    wait_idle(1, "crc_vec_idle");
    check("crc_vec_cnt", 32'(m_cnt[1]), 1);
    check("crc_vec_err", 32'(m_err[1]), 0);

    // Short random frames on the unpadded instance
    for (int r = 0; r < 3; r++) begin
      build(1 + int'($urandom_range(14)), 1 + int'($urandom_range(6)));
      model(1, 0);
      send(1);
      wait_idle(1, "nopad_idle");
    end
    check("nopad_cnt", 32'(m_cnt[1]), 32'(exp_frames[1]));

    // Padding: 4 data nibbles padded to minimum
    build(15, 2);
    model(0, MIN_NIB);
    send(0);
    wait_idle(0, "pad_idle");
    check("pad_burst_len", 32'(last_blen[0]), 16 + 128);
    check("pad_cnt", 32'(m_cnt[0]), 32'(exp_frames[0]));

    // Back-to-back frames at minimum gap
    for (int r = 0; r < 2; r++) begin
      build(15, 10 + int'($urandom_range(60)));
      model(0, MIN_NIB);
      send(0);
      wait_idle(0, "b2b_idle");
    end
    check("b2b_gap", 32'(last_gap[0]), IFG_NIB);
    check("b2b_cnt", 32'(m_cnt[0]), 32'(exp_frames[0]));
    check("b2b_err", 32'(m_err[0]), 0);

    // Random mix of padded and unpadded lengths
    for (int r = 0; r < 8; r++) begin
      build(1 + int'($urandom_range(14)), 1 + int'($urandom_range(90)));
      model(0, MIN_NIB);
      send(0);
      wait_idle(0, "rand_idle");
      cycles(int'($urandom_range(5)));
    end
    check("rand_cnt", 32'(m_cnt[0]), 32'(exp_frames[0]));
    check("rand_err", 32'(m_err[0]), 0);

    // Overrun: valid re-asserted 5 cycles after the last FCS nibble
    build(15, 40);
    model(0, MIN_NIB);
    send(0);
    n = 0;
    while (m_en[0] !== 1'b0 && n < 400) begin cycles(1); n++; end
    check("ovr_txen_fall", 32'(m_en[0]), 0);
    cycles(4);
    for (int i = 0; i < 40; i++) drive(0, 1'b1, 4'(i));
    set_in(0, 1'b0, 4'h0);
    exp_err[0] = 1'b1;
    wait_idle(0, "ovr_idle");
    check("ovr_err", 32'(m_err[0]), 32'(exp_err[0]));
    check("ovr_cnt", 32'(m_cnt[0]), 32'(exp_frames[0]));
    build(15, 30);
    model(0, MIN_NIB);
    send(0);
    wait_idle(0, "ovr_clean_idle");
    check("ovr_clean_cnt", 32'(m_cnt[0]), 32'(exp_frames[0]));

    // Missing SFD
    frm.delete();
    for (int i = 0; i < 10; i++) frm.push_back(4'h5);
    model(0, MIN_NIB);
    send(0);
    cycles(1);
    check("nosfd_busy", 32'(m_busy[0]), 1);
    wait_idle(0, "nosfd_idle");
    check("nosfd_err", 32'(m_err[0]), 1);
    check("nosfd_cnt", 32'(m_cnt[0]), 32'(exp_frames[0]));

    // Reset mid-payload
    build(15, 10);
    for (int i = 0; i < 26; i++) exp_nib.push_back(frm[i]);
    exp_len.push_back(26);
    for (int i = 0; i < 26; i++) drive(0, 1'b1, frm[i]);
    set_in(0, 1'b1, frm[26]);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    set_in(0, 1'b0, 4'h0);
    exp_frames[0] = 0; exp_frames[1] = 0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    check("rst_tx_en", 32'(m_en[0]), 0);
    check("rst_busy", 32'(m_busy[0]), 0);
    check("rst_err", 32'(m_err[0]), 0);
    check("rst_cnt", 32'(m_cnt[0]), 0);
    check("rst_cnt1", 32'(m_cnt[1]), 0);
    cycles(2);
    build(15, 35);
    model(0, MIN_NIB);
    send(0);
    wait_idle(0, "post_rst_idle");
    check("post_rst_cnt", 32'(m_cnt[0]), 1);
    check("post_rst_err", 32'(m_err[0]), 0);

    cycles(5);
    check("exp_nib_left", 32'(exp_nib.size()), 0);
    check("exp_len_left", 32'(exp_len.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
